// File: rtl/down_count_monitor.sv
// Sequence checker for a 4-bit down counter: tracks N -> N-1 mod 16, flags and counts wraps, latches errors.
// Optional registered seven-segment decode of the sampled value is enabled by defining SEG7_EN.
module down_count_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              Q4,
  input  logic              Q3,
  input  logic              Q2,
  input  logic              Q1,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic              locked
`ifdef SEG7_EN
  ,
  output logic [6:0]        seg
`endif
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cur;
  logic [3:0]        prev_p1;
  logic              match;
  logic              wrap_hit;
  logic              tc_nxt;
  logic              err_nxt;
  logic [WRAP_W-1:0] wraps_nxt;

  // Wrap counter holds at all-ones instead of rolling over.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (&v) return v;
    return v + WRAP_W'(1);
  endfunction

  assign cur      = {Q4, Q3, Q2, Q1};
  assign match    = (cur == (prev_p1 - 4'd1));
  assign wrap_hit = (prev_p1 == 4'd0);

  always_comb begin
    state_nxt = state;
    tc_nxt    = 1'b0;
    err_nxt   = err;
    wraps_nxt = wraps;
    unique case (state)
      INIT: begin
        state_nxt = TRACK;
      end
      TRACK: begin
        if (match) begin
          if (wrap_hit) begin
            tc_nxt    = 1'b1;
            wraps_nxt = sat_inc(wraps);
          end
        end else begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end
      end
      ERR: begin
        err_nxt = 1'b1;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // clr outranks the state logic, so a same-edge wrap or mismatch leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      tc     <= 1'b0;
      wraps  <= '0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else if (clr) begin
      state  <= INIT;
      tc     <= 1'b0;
      wraps  <= '0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      tc     <= tc_nxt;
      wraps  <= wraps_nxt;
      err    <= err_nxt;
      locked <= (state == TRACK);
    end
  end

  // Sample stage: prev reloads on every edge, clr included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_p1 <= 4'd0;
    else      prev_p1 <= cur;
  end

`ifdef SEG7_EN
  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg <= 7'b1000000;
    else      seg <= hex7(cur);
  end
`endif

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed vector table, hand sequences and a randomized run against a reference model.
module tb_down_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] qv;

  logic       tc8, err8, locked8;
  logic [7:0] wraps8;
  logic       tc2, err2, locked2;
  logic [1:0] wraps2;
`ifdef SEG7_EN
  logic [6:0] seg8, seg2;
`endif

  down_count_monitor #(.WRAP_W(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr),
    .Q4(qv[3]), .Q3(qv[2]), .Q2(qv[1]), .Q1(qv[0]),
    .tc(tc8), .wraps(wraps8), .err(err8), .locked(locked8)
`ifdef SEG7_EN
    , .seg(seg8)
`endif
  );

  down_count_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr),
    .Q4(qv[3]), .Q3(qv[2]), .Q2(qv[1]), .Q1(qv[0]),
    .tc(tc2), .wraps(wraps2), .err(err2), .locked(locked2)
`ifdef SEG7_EN
    , .seg(seg2)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int S_INIT  = 0;
  localparam int S_TRACK = 1;
  localparam int S_ERR   = 2;

  int         m_state, m_prev, m_tc, m_err, m_locked, m_wraps8, m_wraps2;
  logic [6:0] m_seg;
  logic [6:0] seg_rom [16];

  typedef struct {
    int q;
    bit c;
    int tc;
    int err;
    int lk;
    int w;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void add(int q, bit c, int tc, int err, int lk, int w);
    vec_t v;
    v.q = q; v.c = c; v.tc = tc; v.err = err; v.lk = lk; v.w = w;
    vt.push_back(v);
  endfunction

  task automatic model_reset();
    m_state = S_INIT; m_prev = 0; m_tc = 0; m_err = 0; m_locked = 0;
    m_wraps8 = 0; m_wraps2 = 0; m_seg = 7'b1000000;
  endtask

  // One clock edge of the monitor's rules, applied to the sample q with clear c.
  task automatic model_edge(input int q, input bit c);
    int was_track;
    was_track = (m_state == S_TRACK) ? 1 : 0;
    if (c) begin
      m_state = S_INIT; m_err = 0; m_tc = 0; m_wraps8 = 0; m_wraps2 = 0; m_locked = 0;
    end else begin
      m_locked = was_track;
      m_tc = 0;
      if (m_state == S_INIT) begin
        m_state = S_TRACK;
      end else if (m_state == S_TRACK) begin
        if (q == (m_prev + 15) % 16) begin
          if (m_prev == 0) begin
            m_tc = 1;
            m_wraps8 = (m_wraps8 < 255) ? m_wraps8 + 1 : 255;
            m_wraps2 = (m_wraps2 < 3) ? m_wraps2 + 1 : 3;
          end
        end else begin
          m_state = S_ERR;
          m_err = 1;
        end
      end
    end
    m_prev = q;
    m_seg = seg_rom[q];
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_tc"},       32'(tc8),     32'(m_tc));
    chk({tag, "_err"},      32'(err8),    32'(m_err));
    chk({tag, "_locked"},   32'(locked8), 32'(m_locked));
    chk({tag, "_wraps"},    32'(wraps8),  32'(m_wraps8));
    chk({tag, "_tc_w2"},    32'(tc2),     32'(m_tc));
    chk({tag, "_err_w2"},   32'(err2),    32'(m_err));
    chk({tag, "_wraps_w2"}, 32'(wraps2),  32'(m_wraps2));
`ifdef SEG7_EN
    chk({tag, "_seg"},      32'(seg8),    32'(m_seg));
`endif
  endtask

  task automatic apply(input int q, input bit c);
    qv  = q[3:0];
    clr = c;
    @(posedge clk);
    model_edge(q, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; qv = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset_locked_w2", 32'(locked2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int tcnt8, tcnt2, lastq, q, r;
    bit c;

    seg_rom = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst = 1'b1; clr = 1'b0; qv = 4'd0;
    model_reset();

    // Directed table: clean count with two wraps, break 9 -> 7, clr recovery, clr on a wrap, counter-reset break.
    add(0, 0, 0, 0, 0, 0);
    add(15, 0, 1, 0, 1, 1);
    for (int v = 14; v >= 1; v--) add(v, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(15, 0, 1, 0, 1, 2);
    for (int v = 14; v >= 9; v--) add(v, 0, 0, 0, 1, 2);
    add(7, 0, 0, 1, 1, 2);
    add(6, 0, 0, 1, 0, 2);
    for (int v = 5; v >= 0; v--) add(v, 0, 0, 1, 0, 2);
    add(15, 0, 0, 1, 0, 2);
    add(14, 0, 0, 1, 0, 2);
    add(13, 1, 0, 0, 0, 0);
    add(12, 0, 0, 0, 0, 0);
    add(11, 0, 0, 0, 1, 0);
    for (int v = 10; v >= 0; v--) add(v, 0, 0, 0, 1, 0);
    add(15, 1, 0, 0, 0, 0);
    add(14, 0, 0, 0, 0, 0);
    add(13, 0, 0, 0, 1, 0);
    add(12, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    add(15, 0, 0, 1, 0, 0);

    do_reset();
    foreach (vt[i]) begin
      apply(vt[i].q, vt[i].c);
      chk($sformatf("vec%0d_tc", i),       32'(tc8),     32'(vt[i].tc));
      chk($sformatf("vec%0d_err", i),      32'(err8),    32'(vt[i].err));
      chk($sformatf("vec%0d_locked", i),   32'(locked8), 32'(vt[i].lk));
      chk($sformatf("vec%0d_wraps", i),    32'(wraps8),  32'(vt[i].w));
      chk($sformatf("vec%0d_wraps_w2", i), 32'(wraps2),  32'((vt[i].w > 3) ? 3 : vt[i].w));
    end

    // Five wraps: the 2-bit counter saturates at 3 while tc keeps pulsing.
    do_reset();
    apply(0, 0);
    tcnt8 = 0; tcnt2 = 0;
    for (int k = 0; k < 5; k++) begin
      for (int v = 15; v >= 0; v--) begin
        apply(v, 0);
        tcnt8 += int'(tc8);
        tcnt2 += int'(tc2);
        check_model("sat");
      end
    end
    chk("sat_tc_pulses",    32'(tcnt8),  32'd5);
    chk("sat_tc_pulses_w2", 32'(tcnt2),  32'd5);
    chk("sat_wraps",        32'(wraps8), 32'd5);
    chk("sat_wraps_w2",     32'(wraps2), 32'd3);
    chk("sat_locked",       32'(locked8), 32'd1);

`ifdef SEG7_EN
    apply(1, 0);
    chk("seg_one", 32'(seg8), 32'(7'b1111001));
    apply(15, 0);
    chk("seg_f",   32'(seg8), 32'(7'b0001110));
`endif

    // Asynchronous reset landing between edges.
    apply(14, 0);
    apply(13, 0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    chk("async_rst_locked_w2", 32'(locked2), 32'd0);
    @(posedge clk);
    #1;
    check_model("async_hold");
    @(negedge clk);
    rst = 1'b1;

    // Randomized run: mostly clean counting with jumps, upstream resets and clears.
    apply(7, 0);
    lastq = 7;
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 5);
      if (r >= 5 && r < 10) q = int'($urandom_range(0, 15));
      else if (r >= 10 && r < 13) q = 0;
      else q = (lastq + 15) % 16;
      apply(q, c);
      check_model("rand");
      lastq = q;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
